sram_like_bridge: RTL and testbench

Parametrised memory front-end that connects the MIPS core's single-cycle instruction and data SRAM ports to one shared SRAM-like bus with variable latency (req/addr_ok/data_ok handshake). It serialises the fetch and load/store of each core cycle onto the bus, data first, and raises a stall to the core until both are complete. It sits between the core top level and the SoC bus, replacing the fixed zero-wait SRAM assumption.

---
 rtl/sram_like_bridge.sv | 137 +++++++++++++
 tb/tb_sram_like_bridge.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_bridge.sv
// Serialises core fetch + load/store onto one req/addr_ok/data_ok bus, data first; stall_o holds the core until both are served.
// Zero-wait bus: 3-cycle stall per channel, 5 for both. SRAM_BRIDGE_PERF_EN adds saturating stall/transfer counters.
module sram_like_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  inst_req_i,
    input  logic [ADDR_W-1:0]     inst_addr_i,
    output logic [DATA_W-1:0]     inst_rdata_o,
    input  logic                  data_en_i,
    input  logic [DATA_W/8-1:0]   data_wen_i,
    input  logic [ADDR_W-1:0]     data_addr_i,
    input  logic [DATA_W-1:0]     data_wdata_i,
    output logic [DATA_W-1:0]     data_rdata_o,
    output logic                  stall_o,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DATA_W-1:0]     bus_rdata
`ifdef SRAM_BRIDGE_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_xfer_cnt
`endif
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_D  = 3'd1,
        WAIT_D = 3'd2,
        REQ_I  = 3'd3,
        WAIT_I = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic   inst_done, data_done;
    logic   inst_pend, data_pend;
    logic   data_is_wr;
    logic   data_fin, inst_fin;

    assign inst_pend  = inst_req_i & ~inst_done;
    assign data_pend  = data_en_i & ~data_done;
    assign stall_o    = inst_pend | data_pend;
    assign data_is_wr = |data_wen_i;
    assign data_fin   = (state == WAIT_D) & bus_data_ok;
    assign inst_fin   = (state == WAIT_I) & bus_data_ok;

    always_comb begin
        state_nxt = state;
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_wstrb = '0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state)
            IDLE: begin
                if (data_pend)      state_nxt = REQ_D;
                else if (inst_pend) state_nxt = REQ_I;
            end
            REQ_D: begin
                bus_req   = 1'b1;
                bus_wr    = data_is_wr;
                bus_wstrb = data_wen_i;
                bus_addr  = data_addr_i;
                bus_wdata = data_wdata_i;
                if (bus_addr_ok) state_nxt = WAIT_D;
            end
            WAIT_D: begin
                if (bus_data_ok) state_nxt = inst_pend ? REQ_I : IDLE;
            end
            REQ_I: begin
                bus_req  = 1'b1;
                bus_addr = inst_addr_i;
                if (bus_addr_ok) state_nxt = WAIT_I;
            end
            WAIT_I: begin
                if (bus_data_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Done flags live for one core cycle: they clear on the edge where the core advances.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_done <= 1'b0;
            data_done <= 1'b0;
        end else if (!stall_o) begin
            inst_done <= 1'b0;
            data_done <= 1'b0;
        end else begin
            if (data_fin) data_done <= 1'b1;
            if (inst_fin) inst_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_rdata_o <= '0;
            data_rdata_o <= '0;
        end else begin
            if (data_fin && !data_is_wr) data_rdata_o <= bus_rdata;
            if (inst_fin)                inst_rdata_o <= bus_rdata;
        end
    end

`ifdef SRAM_BRIDGE_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_stall_cnt <= '0;
            perf_xfer_cnt  <= '0;
        end else begin
            if (stall_o && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if ((data_fin || inst_fin) && (perf_xfer_cnt != 32'hFFFF_FFFF))
                perf_xfer_cnt <= perf_xfer_cnt + 32'd1;
        end
    end
`endif

    logic unused_strb_w;
    assign unused_strb_w = (STRB_W == DATA_W / 8);

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge with a negedge-driven variable-latency bus model.
module tb_sram_like_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req_i = 1'b0;
    logic [31:0] inst_addr_i = '0;
    logic [31:0] inst_rdata_o;
    logic        data_en_i = 1'b0;
    logic [3:0]  data_wen_i = '0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic [31:0] data_rdata_o;
    logic        stall_o;
    logic        bus_req, bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = '0;
`ifdef SRAM_BRIDGE_PERF_EN
    logic [31:0] perf_stall_cnt, perf_xfer_cnt;
`endif

    sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_rdata_o(inst_rdata_o),
        .data_en_i(data_en_i), .data_wen_i(data_wen_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .stall_o(stall_o),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata)
`ifdef SRAM_BRIDGE_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_xfer_cnt(perf_xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C08_0001;
        if (a == 32'h8000_1000) return 32'h1234_5678;
        return a ^ 32'h0000_5A5A;
    endfunction

    // Bus model: addr_ok after addr_dly extra req cycles, data_ok after data_dly extra wait cycles.
    int          addr_dly = 0, data_dly = 0;
    int          rcnt = 0, wcnt = 0, req_cycles = 0;
    bit          pend = 0, stray = 0;
    logic [31:0] pend_addr;
    logic [68:0] held;
    logic [31:0] log_addr[$];
    bit          log_wr[$];
    logic [3:0]  log_strb[$];
    logic [31:0] log_wdata[$];

    always @(negedge clk) begin
        bus_addr_ok = 1'b0;
        bus_data_ok = stray;
        if (!resetn) begin
            pend = 0; rcnt = 0; wcnt = 0;
        end else if (pend) begin
            if (wcnt == data_dly) begin
                bus_data_ok = 1'b1;
                bus_rdata   = mem_rd(pend_addr);
                pend        = 0;
            end else wcnt++;
        end else if (bus_req) begin
            req_cycles++;
            if (rcnt == 0) held = {bus_wr, bus_wstrb, bus_addr, bus_wdata};
            else chk("req_hold", 64'(held != {bus_wr, bus_wstrb, bus_addr, bus_wdata}), 64'd0);
            if (rcnt == addr_dly) begin
                bus_addr_ok = 1'b1;
                log_addr.push_back(bus_addr);
                log_wr.push_back(bus_wr);
                log_strb.push_back(bus_wstrb);
                log_wdata.push_back(bus_wdata);
                pend_addr = bus_addr;
                pend = 1; wcnt = 0; rcnt = 0;
            end else rcnt++;
        end
        if (!bus_req && resetn)
            chk("idle_zero", 64'(|{bus_wr, bus_wstrb, bus_addr, bus_wdata}), 64'd0);
    end

    task automatic access(input bit ireq, input logic [31:0] iaddr, input bit den,
                          input logic [3:0] wen, input logic [31:0] daddr,
                          input logic [31:0] wdata, output int stalls);
        log_addr.delete(); log_wr.delete(); log_strb.delete(); log_wdata.delete();
        req_cycles = 0;
        @(posedge clk); #1;
        inst_req_i = ireq; inst_addr_i = iaddr;
        data_en_i = den; data_wen_i = wen; data_addr_i = daddr; data_wdata_i = wdata;
        stalls = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!stall_o) break;
            stalls++;
        end
        if (stalls >= 100) chk("stall_timeout", 64'(stalls), 64'd0);
    endtask

    task automatic release_core();
        @(posedge clk); #1;
        inst_req_i = 0; data_en_i = 0; data_wen_i = '0;
    endtask

    int st;
`ifdef SRAM_BRIDGE_PERF_EN
    logic [31:0] ps0, px0;
`endif

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_inst_rdata", 64'(inst_rdata_o), 64'd0);
        chk("rst_data_rdata", 64'(data_rdata_o), 64'd0);
        resetn = 1'b1;

        // Fetch only, zero-wait bus.
        access(1, 32'hBFC0_0000, 0, 4'h0, 32'h0, 32'h0, st);
        chk("fetch_stall", 64'(st), 64'd3);
        chk("fetch_rdata", 64'(inst_rdata_o), 64'h3C08_0001);
        chk("fetch_nxfer", 64'(log_addr.size()), 64'd1);
        chk("fetch_addr", 64'(log_addr[0]), 64'hBFC0_0000);
        release_core();

        // Load + fetch: data goes out first.
`ifdef SRAM_BRIDGE_PERF_EN
        ps0 = perf_stall_cnt; px0 = perf_xfer_cnt;
`endif
        access(1, 32'hBFC0_0004, 1, 4'h0, 32'h8000_1000, 32'h0, st);
        chk("lf_stall", 64'(st), 64'd5);
        chk("lf_nxfer", 64'(log_addr.size()), 64'd2);
        chk("lf_first_addr", 64'(log_addr[0]), 64'h8000_1000);
        chk("lf_first_wr", 64'(log_wr[0]), 64'd0);
        chk("lf_second_addr", 64'(log_addr[1]), 64'hBFC0_0004);
        chk("lf_data_rdata", 64'(data_rdata_o), 64'h1234_5678);
        chk("lf_inst_rdata", 64'(inst_rdata_o), 64'hBFC0_5A5E);
        release_core();
`ifdef SRAM_BRIDGE_PERF_EN
        chk("perf_stall", 64'(perf_stall_cnt - ps0), 64'd5);
        chk("perf_xfer", 64'(perf_xfer_cnt - px0), 64'd2);
`endif

        // Partial store leaves load data untouched.
        access(0, 32'h0, 1, 4'b0011, 32'h8000_2000, 32'hAABB_CCDD, st);
        chk("st_stall", 64'(st), 64'd3);
        chk("st_wr", 64'(log_wr[0]), 64'd1);
        chk("st_wstrb", 64'(log_strb[0]), 64'h3);
        chk("st_wdata", 64'(log_wdata[0]), 64'hAABB_CCDD);
        chk("st_addr", 64'(log_addr[0]), 64'h8000_2000);
        chk("st_data_rdata", 64'(data_rdata_o), 64'h1234_5678);
        release_core();

        // Slow bus: req held 4 cycles, data_ok on the 4th wait cycle -> 1+4+4 stall cycles.
        addr_dly = 3; data_dly = 3;
        access(1, 32'hBFC0_0008, 0, 4'h0, 32'h0, 32'h0, st);
        chk("slow_stall", 64'(st), 64'd9);
        chk("slow_req_cycles", 64'(req_cycles), 64'd4);
        chk("slow_rdata", 64'(inst_rdata_o), 64'hBFC0_5A52);
        release_core();
        addr_dly = 0; data_dly = 0;

        // Stray data_ok while idle must not disturb anything.
        @(posedge clk); #1 stray = 1;
        @(posedge clk); #1 stray = 0;
        @(negedge clk);
        chk("stray_stall", 64'(stall_o), 64'd0);
        chk("stray_bus_req", 64'(bus_req), 64'd0);
        chk("stray_inst_rdata", 64'(inst_rdata_o), 64'hBFC0_5A52);
        access(1, 32'hBFC0_0000, 0, 4'h0, 32'h0, 32'h0, st);
        chk("post_stray_stall", 64'(st), 64'd3);
        chk("post_stray_rdata", 64'(inst_rdata_o), 64'h3C08_0001);
        release_core();

        // Reset while the load sits in WAIT_D.
        data_dly = 5;
        @(posedge clk); #1;
        data_en_i = 1; data_addr_i = 32'h8000_1000;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_bus_req", 64'(bus_req), 64'd0);
        chk("mid_rst_stall", 64'(stall_o), 64'd1);
        chk("mid_rst_inst_rdata", 64'(inst_rdata_o), 64'd0);
        chk("mid_rst_data_rdata", 64'(data_rdata_o), 64'd0);
        @(negedge clk);
        chk("mid_rst_hold_req", 64'(bus_req), 64'd0);
        data_en_i = 0;
        data_dly = 0;
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("after_rst_stall", 64'(stall_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
